// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input.
//
// The input is synchronized and then edge-detected. Each completed cycle,
// measured from one rising edge to the next, is reported with a one-cycle
// valid strobe. If no edge is seen for MAX cycles the block flags the input
// as stuck and reports the level it is stuck at.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   pwm_in       asynchronous PWM input
//   period       cycles between the last two rising edges (held)
//   high_time    cycles high within that period (held)
//   valid        one-cycle pulse when period/high_time update
//   stuck        no edge seen for MAX cycles
//   stuck_level  synchronized input level while stuck
module pwm_capture #(
  parameter int unsigned CNT_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_in,
  output logic [CNT_LEN-1:0] period,
  output logic [CNT_LEN-1:0] high_time,
  output logic               valid,
  output logic               stuck,
  output logic               stuck_level
);

  localparam logic [CNT_LEN-1:0] MAX = '1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic               s1;
  logic               s2;
  logic               prev;
  logic               rise;
  logic               fall;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [CNT_LEN-1:0] cnt;
  logic [CNT_LEN-1:0] cnt_nxt;
  logic [CNT_LEN-1:0] cnt_inc;
  logic               at_max;
  logic [CNT_LEN-1:0] hi_cap;
  logic [CNT_LEN-1:0] hi_cap_nxt;
  logic [CNT_LEN-1:0] period_nxt;
  logic [CNT_LEN-1:0] high_time_nxt;
  logic               valid_nxt;
  logic               stuck_nxt;
  logic               stuck_level_nxt;

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;

  // Saturating increment; cnt parks at MAX once a timeout has been reached.
  assign at_max  = (cnt == MAX);
  assign cnt_inc = at_max ? MAX : cnt + CNT_LEN'(1);

  // State and measurement registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_cap      <= '0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hi_cap      <= hi_cap_nxt;
      period      <= period_nxt;
      high_time   <= high_time_nxt;
      valid       <= valid_nxt;
      stuck       <= stuck_nxt;
      stuck_level <= stuck_level_nxt;
    end
  end

  // Next-state and next-output logic. Edges are checked before the timeout
  // so that a period of exactly MAX is still reported.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt_inc;
    hi_cap_nxt      = hi_cap;
    period_nxt      = period;
    high_time_nxt   = high_time;
    valid_nxt       = 1'b0;
    stuck_nxt       = stuck;
    stuck_level_nxt = stuck_level;

    case (state)
      IDLE: begin
        // First rising edge only arms the measurement.
        if (rise) begin
          cnt_nxt   = CNT_LEN'(1);
          stuck_nxt = 1'b0;
          state_nxt = HIGH;
        end else if (fall) begin
          cnt_nxt   = CNT_LEN'(1);
          stuck_nxt = 1'b0;
        end else if (at_max) begin
          stuck_nxt       = 1'b1;
          stuck_level_nxt = s2;
        end
      end

      HIGH: begin
        if (fall) begin
          hi_cap_nxt = cnt;
          state_nxt  = LOW;
        end else if (at_max) begin
          state_nxt       = IDLE;
          stuck_nxt       = 1'b1;
          stuck_level_nxt = s2;
        end
      end

      LOW: begin
        if (rise) begin
          period_nxt    = cnt;
          high_time_nxt = hi_cap;
          valid_nxt     = 1'b1;
          cnt_nxt       = CNT_LEN'(1);
          state_nxt     = HIGH;
        end else if (at_max) begin
          state_nxt       = IDLE;
          stuck_nxt       = 1'b1;
          stuck_level_nxt = s2;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
